// File: rtl/dot4_sequencer.sv
// Steps the four-way operand mux through elements 0..3 and accumulates the
// signed dot product of the mux outputs with coefficients latched at start.
module dot4_sequencer #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     coef0,
  input  logic [N-1:0]     coef1,
  input  logic [N-1:0]     coef2,
  input  logic [N-1:0]     coef3,
  output logic [1:0]       option,
  input  logic [N-1:0]     mux_data,
  output logic             busy,
  output logic             done,
  output logic [2*N+1:0]   result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [1:0]             idx;
  logic signed [N-1:0]    coef_q [4];
  logic signed [2*N+1:0]  acc;
  logic signed [2*N-1:0]  a_ext;
  logic signed [2*N-1:0]  b_ext;
  logic signed [2*N-1:0]  prod;
  logic signed [2*N+1:0]  sum;

  // Both operands widened explicitly so the multiply is a true 2N-bit signed product.
  assign a_ext = {{N{mux_data[N-1]}}, mux_data};
  assign b_ext = {{N{coef_q[idx][N-1]}}, coef_q[idx]};
  assign prod  = a_ext * b_ext;
  assign sum   = acc + {{2{prod[2*N-1]}}, prod};

  // idx wraps back to 0 when RUN ends, so it doubles as the registered mux select.
  assign option = idx;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 2'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      // NOTE: the coefficient array is small and explicitly cleared on reset;
      // larger RAM-style arrays would normally be left unreset.
      for (int i = 0; i < 4; i++) coef_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            coef_q[0] <= coef0;
            coef_q[1] <= coef1;
            coef_q[2] <= coef2;
            coef_q[3] <= coef3;
            acc       <= '0;
            idx       <= 2'd0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          acc <= sum;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            result <= sum;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          idx   <= 2'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot4_sequencer.sv
// Bench for dot4_sequencer: a four-entry mux model driven by the DUT select,
// a table of dot-product vectors and hand-written multi-cycle sequences.
module tb_dot4_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] coef0, coef1, coef2, coef3;
  logic [1:0] option;
  logic [3:0] mux_data;
  logic       busy;
  logic       done;
  logic [9:0] result;

  logic [3:0] mult [4];

  assign mux_data = mult[option];

  always #5 clk = ~clk;

  dot4_sequencer #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .coef0    (coef0),
    .coef1    (coef1),
    .coef2    (coef2),
    .coef3    (coef3),
    .option   (option),
    .mux_data (mux_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  typedef struct {
    string name;
    int    m [4];
    int    c [4];
    int    exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int sb [$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int res_s();
    return int'($signed(result));
  endfunction

  task automatic load(input int m0, m1, m2, m3, c0, c1, c2, c3);
    mult[0] = m0[3:0];
    mult[1] = m1[3:0];
    mult[2] = m2[3:0];
    mult[3] = m3[3:0];
    coef0   = c0[3:0];
    coef1   = c1[3:0];
    coef2   = c2[3:0];
    coef3   = c3[3:0];
  endtask

  task automatic junk_coef();
    coef0 = 4'($urandom);
    coef1 = 4'($urandom);
    coef2 = 4'($urandom);
    coef3 = 4'($urandom);
  endtask

  // Scoreboard: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) check("unexpected_done", int'(done), 0);
      else check("sb_result", res_s(), sb.pop_front());
    end
  end

  // One full transaction with cycle-by-cycle checks of option/busy/done.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    load(v.m[0], v.m[1], v.m[2], v.m[3], v.c[0], v.c[1], v.c[2], v.c[3]);
    start = 1'b1;
    sb.push_back(v.exp);
    @(negedge clk);
    start = 1'b0;
    junk_coef();
    for (int k = 0; k < 4; k++) begin
      check({v.name, "_option"}, int'(option), k);
      check({v.name, "_busy"}, int'(busy), 1);
      check({v.name, "_done_low"}, int'(done), 0);
      @(negedge clk);
    end
    check({v.name, "_done"}, int'(done), 1);
    check({v.name, "_busy_done"}, int'(busy), 0);
    check({v.name, "_option_done"}, int'(option), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    vec_t vecs [4];
    vec_t mixed;
    vecs[0] = '{name: "neg8_neg8", m: '{-8, -8, -8, -8}, c: '{-8, -8, -8, -8}, exp:  256};
    vecs[1] = '{name: "neg8_pos7", m: '{-8, -8, -8, -8}, c: '{ 7,  7,  7,  7}, exp: -224};
    vecs[2] = '{name: "mixed",     m: '{ 3, -2,  5, -1}, c: '{-4,  6,  2,  7}, exp:  -21};
    vecs[3] = '{name: "basic",     m: '{ 1,  2,  3,  4}, c: '{ 1,  1,  1,  1}, exp:   10};
    mixed   = vecs[2];

    rst   = 1'b1;
    start = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_option", int'(option), 0);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_result", res_s(),      0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Result must hold with random mux data and no start.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) mult[j] = 4'($urandom);
      check("hold_result", res_s(),    10);
      check("hold_done",   int'(done), 0);
    end

    // start held high: accepted at t, t+6, t+12 with re-latched operands.
    @(negedge clk);
    load(1, 2, 3, 4, 2, 2, 2, 2);
    start = 1'b1;
    sb.push_back(20);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("held_done", int'(done), (k % 6 == 5) ? 1 : 0);
      check("held_busy", int'(busy), (k % 6 >= 1 && k % 6 <= 4) ? 1 : 0);
      if (k % 6 >= 1 && k % 6 <= 4) begin
        check("held_option", int'(option), (k % 6) - 1);
        junk_coef();
      end
      if (k == 5) begin
        load(-1, -1, -1, -1, 3, 3, 3, 3);
        sb.push_back(-12);
      end
      if (k == 11) begin
        load(7, 0, -3, 1, 1, 5, 2, -8);
        sb.push_back(-7);
      end
      if (k == 17) start = 1'b0;
    end

    // Reset at edge t+2 aborts the run without a done pulse.
    @(negedge clk);
    load(1, 2, 3, 4, 1, 1, 1, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy", int'(busy), 1);
    @(negedge clk);
    check("abort_option_mid", int'(option), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_option", int'(option), 0);
    check("abort_busy0",  int'(busy),   0);
    check("abort_done",   int'(done),   0);
    check("abort_result", res_s(),      0);
    rst = 1'b0;
    run_vec(mixed);

    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
